// File: rtl/sram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arbiter_pkg
//   Shared types and constants for the two-port async SRAM arbiter.
//   - state_e      : access sequencer states
//   - ADDR_W_DEF / DATA_W_DEF / ACCESS_CYC_DEF : default geometry and timing
//   - PORT_A / PORT_B : requester identifiers used by the grant logic
//   - is_bus_phase : true in the states where the SRAM chip is selected
// ----------------------------------------------------------------------------
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF     = 18;
    localparam int DATA_W_DEF     = 16;
    localparam int ACCESS_CYC_DEF = 3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_e;

    // SETUP, ACCESS and HOLD are the states in which CE_n is asserted.
    function automatic logic is_bus_phase(input state_e s);
        return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// sram_rr_arb2
//   Two-way round-robin grant. The grant is combinational from the current
//   requests and the last-granted port; the last-grant register only moves
//   when the parent accepts a grant (en_i high with a valid request).
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     req_a_i, req_b_i  requests from port A / port B
//     en_i              parent is able to accept a grant this cycle
//     gnt_valid_o       at least one request present
//     gnt_port_o        PORT_A or PORT_B, meaningful when gnt_valid_o
// ----------------------------------------------------------------------------
module sram_rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic en_i,
    output logic gnt_valid_o,
    output logic gnt_port_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_valid_o = req_a_i | req_b_i;
        gnt_port_o  = PORT_A;
        if (req_a_i && req_b_i) begin
            // Tie: whoever did not win last time goes now.
            gnt_port_o = (last_q == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b_i) begin
            gnt_port_o = PORT_B;
        end
        last_d = (en_i && gnt_valid_o) ? gnt_port_o : last_q;
    end

    // Reset to B so that A wins the first tie after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
//   Two-port arbiter and access sequencer for an asynchronous 256Kx16 SRAM.
//   Ports A and B issue single-word requests; grants alternate on contention.
//   Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYC clocks) -> HOLD ->
//   TURN -> IDLE. All SRAM control pins come straight from flops so the
//   asynchronous strobes never see decode glitches.
//   Ports:
//     CLOCK_50_B5B, reset     clock, asynchronous active-high reset
//     a_req/a_we/a_addr/a_wdata/a_be   port A request (held until a_ack)
//     a_ack, a_rvalid, a_rdata         port A handshake and read data
//     b_*                              identical set for port B
//     sram_addr, sram_*_n, sram_dq     SRAM pins (sole owner)
//     busy                             high whenever the sequencer is not IDLE
// ----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACCESS_CYC = ACCESS_CYC_DEF
) (
    input  logic              CLOCK_50_B5B,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    inout  wire  [DATA_W-1:0] sram_dq,

    output logic              busy
);

    localparam int CNT_W = $clog2(ACCESS_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);

    // Sequencer state and latched request
    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                port_q,   port_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [1:0]          be_q,     be_d;

    // Requester-side outputs
    logic                a_ack_q,    a_ack_d;
    logic                b_ack_q,    b_ack_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q,  a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q,  b_rdata_d;

    // SRAM pin flops
    logic                ce_n_q,  ce_n_d;
    logic                oe_n_q,  oe_n_d;
    logic                we_n_q,  we_n_d;
    logic                lb_n_q,  lb_n_d;
    logic                ub_n_q,  ub_n_d;
    logic                dq_oe_q, dq_oe_d;

    // Arbitration
    logic                arb_en;
    logic                gnt_valid;
    logic                gnt_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [1:0]          sel_be;

    assign arb_en = (state_q == ST_IDLE);

    sram_rr_arb2 u_rr_arb2 (
        .clk_i       (CLOCK_50_B5B),
        .rst_i       (reset),
        .req_a_i     (a_req),
        .req_b_i     (b_req),
        .en_i        (arb_en),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    assign sel_we    = (gnt_port == PORT_A) ? a_we    : b_we;
    assign sel_addr  = (gnt_port == PORT_A) ? a_addr  : b_addr;
    assign sel_wdata = (gnt_port == PORT_A) ? a_wdata : b_wdata;
    assign sel_be    = (gnt_port == PORT_A) ? a_be    : b_be;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    if (gnt_port == PORT_A) begin
                        a_ack_d = 1'b1;
                    end else begin
                        b_ack_d = 1'b1;
                    end
                    if (sel_be == 2'b00) begin
                        // No lanes selected: skip the SRAM cycle entirely.
                        // A read still completes, with rdata left untouched.
                        state_d = ST_TURN;
                        if (!sel_we) begin
                            if (gnt_port == PORT_A) begin
                                a_rvalid_d = 1'b1;
                            end else begin
                                b_rvalid_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                    // Sample the bus at the end of the data-valid window.
                    if (!we_q) begin
                        if (port_q == PORT_A) begin
                            a_rdata_d = sram_dq;
                        end else begin
                            b_rdata_d = sram_dq;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                state_d = ST_TURN;
                if (!we_q) begin
                    if (port_q == PORT_A) begin
                        a_rvalid_d = 1'b1;
                    end else begin
                        b_rvalid_d = 1'b1;
                    end
                end
            end

            ST_TURN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin decode from the next state so the pins are registered and
        // line up with the state they belong to.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (is_bus_phase(state_d)) begin
            ce_n_d = 1'b0;
            lb_n_d = ~be_d[0];
            ub_n_d = ~be_d[1];
            if (we_d) begin
                // OE_n stays high for the whole write, so the DQ driver
                // can never fight the SRAM outputs.
                dq_oe_d = 1'b1;
                we_n_d  = (state_d != ST_ACCESS);
            end else begin
                oe_n_d = (state_d == ST_HOLD);
            end
        end
    end

    always_ff @(posedge CLOCK_50_B5B or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 2'b00;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_ub_n = ub_n_q;
    assign busy      = (state_q != ST_IDLE);

    // The only driver of the shared data bus.
    assign sram_dq = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_ack, a_rvalid, b_ack, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [17:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    wire  [15:0] sram_dq;
    logic        busy;

    int checks;
    int failures;

    sram_arbiter dut (
        .CLOCK_50_B5B (clk),
        .reset        (reset),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_be         (a_be),
        .a_ack        (a_ack),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_be         (b_be),
        .b_ack        (b_ack),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .sram_addr    (sram_addr),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_lb_n    (sram_lb_n),
        .sram_ub_n    (sram_ub_n),
        .sram_dq      (sram_dq),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural async SRAM (low 256 words): write commits on WE_n rise.
    logic [15:0] mem [0:255] = '{default: 16'h0000};

    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0) begin
            if (sram_lb_n === 1'b0) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (sram_ub_n === 1'b0) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    assign sram_dq = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && sram_we_n === 1'b1)
                     ? mem[sram_addr[7:0]] : 16'hzzzz;

    typedef struct {
        int ack_lat;
        int rv_lat;
        int acks;
        int cycles;
        int ce_low;
        int oe_low;
        int we_low;
        int lb_low;
        int ub_low;
        int dq_drv;
        int other;
    } obs_t;

    // Issue one request on one port and record what the pins did, cycle by
    // cycle, until the sequencer returns to IDLE (bounded at 20 cycles).
    task automatic do_req(input logic port, input logic we, input logic [17:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be, output obs_t o);
        logic my_ack, my_rv, ot;
        o = '{default: 0};
        o.ack_lat = -1;
        o.rv_lat  = -1;
        @(negedge clk);
        if (port == 1'b0) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            my_ack = port ? b_ack : a_ack;
            my_rv  = port ? b_rvalid : a_rvalid;
            ot     = port ? (a_ack | a_rvalid) : (b_ack | b_rvalid);
            if (my_ack) o.acks++;
            if (my_ack && o.ack_lat < 0) begin
                o.ack_lat = c;
                a_req = 1'b0;
                b_req = 1'b0;
            end
            if (my_rv) o.rv_lat = c;
            if (ot) o.other++;
            if (!sram_ce_n) o.ce_low++;
            if (!sram_oe_n) o.oe_low++;
            if (!sram_we_n) o.we_low++;
            if (!sram_lb_n) o.lb_low++;
            if (!sram_ub_n) o.ub_low++;
            if (sram_dq === wdata) o.dq_drv++;
            if (o.ack_lat >= 0 && !busy) begin
                o.cycles = c;
                break;
            end
        end
        $display("txn port=%s we=%0d addr=%05h wdata=%04h be=%b ack_lat=%0d rv_lat=%0d cycles=%0d",
                 port ? "B" : "A", we, addr, wdata, be, o.ack_lat, o.rv_lat, o.cycles);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sram_ce_n !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%b want=1", sram_ce_n); end
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b want=1", sram_oe_n); end
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
        checks++; if ({sram_lb_n, sram_ub_n} !== 2'b11) begin failures++; $display("FAIL reset_lb_ub got=%b want=11", {sram_lb_n, sram_ub_n}); end
        checks++; if (sram_addr !== 18'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
        checks++; if ({a_ack, b_ack, a_rvalid, b_rvalid} !== 4'b0) begin failures++; $display("FAIL reset_handshake got=%b want=0000", {a_ack, b_ack, a_rvalid, b_rvalid}); end
        checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", a_rdata, b_rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Both ports request in the same cycle while reset is released; both
    // stay asserted so every IDLE re-arbitrates.
    task automatic test_arbitration();
        int ack_t[4];
        logic ack_p[4];
        int n;
        int seen_in_reset;
        ack_t = '{-100, -100, -100, -100};
        ack_p = '{1'b1, 1'b0, 1'b1, 1'b0};
        n = 0;
        seen_in_reset = 0;
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00020; a_wdata = 16'hA020; a_be = 2'b11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00021; b_wdata = 16'hB021; b_be = 2'b11;
        repeat (2) begin
            @(negedge clk);
            if (a_ack || b_ack) seen_in_reset++;
        end
        reset = 1'b0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(negedge clk);
            if (a_ack && n < 4) begin ack_p[n] = 1'b0; ack_t[n] = c; n++; end
            if (b_ack && n < 4) begin ack_p[n] = 1'b1; ack_t[n] = c; n++; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        $display("txn arbitration acks=%0d order=%0d%0d%0d%0d times=%0d,%0d,%0d,%0d",
                 n, ack_p[0], ack_p[1], ack_p[2], ack_p[3], ack_t[0], ack_t[1], ack_t[2], ack_t[3]);
        checks++; if (seen_in_reset != 0) begin failures++; $display("FAIL arb_ack_in_reset got=%0d want=0", seen_in_reset); end
        checks++; if (n != 4) begin failures++; $display("FAIL arb_ack_count got=%0d want=4", n); end
        checks++; if (ack_t[0] != 1) begin failures++; $display("FAIL arb_first_ack_cycle got=%0d want=1", ack_t[0]); end
        checks++; if ({ack_p[0], ack_p[1], ack_p[2], ack_p[3]} !== 4'b0101) begin failures++; $display("FAIL arb_order got=%b want=0101 (A,B,A,B)", {ack_p[0], ack_p[1], ack_p[2], ack_p[3]}); end
        checks++; if (ack_t[1] - ack_t[0] != 7) begin failures++; $display("FAIL arb_back_to_back got=%0d want=7", ack_t[1] - ack_t[0]); end
        checks++; if (mem[8'h20] !== 16'hA020 || mem[8'h21] !== 16'hB021) begin failures++; $display("FAIL arb_mem got=%h/%h want=a020/b021", mem[8'h20], mem[8'h21]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arb_idle_timeout got=%b want=0", busy); end
    endtask

    task automatic test_write_a();
        obs_t o;
        do_req(1'b0, 1'b1, 18'h00010, 16'hBEEF, 2'b11, o);
        checks++; if (o.ack_lat != 1) begin failures++; $display("FAIL wr_ack_lat got=%0d want=1", o.ack_lat); end
        checks++; if (o.acks != 1) begin failures++; $display("FAIL wr_ack_pulses got=%0d want=1", o.acks); end
        checks++; if (o.we_low != 3) begin failures++; $display("FAIL wr_we_low got=%0d want=3", o.we_low); end
        checks++; if (o.dq_drv != 5) begin failures++; $display("FAIL wr_dq_driven got=%0d want=5", o.dq_drv); end
        checks++; if (o.ce_low != 5) begin failures++; $display("FAIL wr_ce_low got=%0d want=5", o.ce_low); end
        checks++; if (o.oe_low != 0) begin failures++; $display("FAIL wr_oe_low got=%0d want=0", o.oe_low); end
        checks++; if (o.lb_low != 5 || o.ub_low != 5) begin failures++; $display("FAIL wr_lanes got=%0d/%0d want=5/5", o.lb_low, o.ub_low); end
        checks++; if (o.rv_lat != -1 || o.other != 0) begin failures++; $display("FAIL wr_no_rvalid got=%0d/%0d want=-1/0", o.rv_lat, o.other); end
        checks++; if (o.cycles != 7) begin failures++; $display("FAIL wr_cycles got=%0d want=7", o.cycles); end
        checks++; if (sram_dq === 16'hBEEF) begin failures++; $display("FAIL wr_dq_released got=%h want=Z", sram_dq); end
        checks++; if (mem[8'h10] !== 16'hBEEF) begin failures++; $display("FAIL wr_mem got=%h want=beef", mem[8'h10]); end
    endtask

    task automatic test_read_b();
        obs_t o;
        do_req(1'b1, 1'b0, 18'h00010, 16'hDEAD, 2'b11, o);
        checks++; if (o.ack_lat != 1) begin failures++; $display("FAIL rd_ack_lat got=%0d want=1", o.ack_lat); end
        checks++; if (o.rv_lat - o.ack_lat != 5) begin failures++; $display("FAIL rd_rvalid_lat got=%0d want=5", o.rv_lat - o.ack_lat); end
        checks++; if (b_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h want=beef", b_rdata); end
        checks++; if (o.oe_low != 4) begin failures++; $display("FAIL rd_oe_low got=%0d want=4", o.oe_low); end
        checks++; if (o.we_low != 0) begin failures++; $display("FAIL rd_we_low got=%0d want=0", o.we_low); end
        checks++; if (o.dq_drv != 0) begin failures++; $display("FAIL rd_dut_drove_dq got=%0d want=0", o.dq_drv); end
        checks++; if (a_rdata !== 16'h0000 || o.other != 0) begin failures++; $display("FAIL rd_port_isolation got=%h/%0d want=0000/0", a_rdata, o.other); end
    endtask

    task automatic test_partial_write();
        obs_t o;
        do_req(1'b0, 1'b1, 18'h00010, 16'h1234, 2'b01, o);
        checks++; if (o.lb_low != 5 || o.ub_low != 0) begin failures++; $display("FAIL pw_lanes got=%0d/%0d want=5/0", o.lb_low, o.ub_low); end
        do_req(1'b0, 1'b0, 18'h00010, 16'hDEAD, 2'b11, o);
        checks++; if (a_rdata !== 16'hBE34) begin failures++; $display("FAIL pw_readback got=%h want=be34", a_rdata); end
        checks++; if (o.rv_lat - o.ack_lat != 5) begin failures++; $display("FAIL pw_rvalid_lat got=%0d want=5", o.rv_lat - o.ack_lat); end
    endtask

    task automatic test_be_zero();
        obs_t o;
        do_req(1'b1, 1'b0, 18'h00010, 16'hDEAD, 2'b00, o);
        checks++; if (o.ack_lat != 1) begin failures++; $display("FAIL be0_ack_lat got=%0d want=1", o.ack_lat); end
        checks++; if (o.rv_lat != 1) begin failures++; $display("FAIL be0_rvalid got=%0d want=1", o.rv_lat); end
        checks++; if (o.ce_low != 0 || o.oe_low != 0) begin failures++; $display("FAIL be0_no_strobe got=%0d/%0d want=0/0", o.ce_low, o.oe_low); end
        checks++; if (b_rdata !== 16'hBEEF) begin failures++; $display("FAIL be0_rdata_held got=%h want=beef", b_rdata); end
        checks++; if (o.cycles != 2) begin failures++; $display("FAIL be0_cycles got=%0d want=2", o.cycles); end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        int reached;
        int stray;
        reached = 0;
        stray = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00030; a_wdata = 16'hCAFE; a_be = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ack) a_req = 1'b0;
            if (!sram_we_n) begin reached = 1; break; end
        end
        a_req = 1'b0;
        checks++; if (reached != 1) begin failures++; $display("FAIL rst_mid_reach_access got=%0d want=1", reached); end
        #2 reset = 1'b1;
        #1;
        checks++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1) begin failures++; $display("FAIL rst_mid_strobes got=%b%b want=11", sram_we_n, sram_ce_n); end
        checks++; if (sram_dq === 16'hCAFE) begin failures++; $display("FAIL rst_mid_dq got=%h want=Z", sram_dq); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        repeat (2) begin
            @(negedge clk);
            if (a_ack || a_rvalid || b_ack || b_rvalid) stray++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack || a_rvalid || b_ack || b_rvalid) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL rst_mid_stray_handshake got=%0d want=0", stray); end
        do_req(1'b1, 1'b1, 18'h00040, 16'h55AA, 2'b11, o);
        checks++; if (o.ack_lat != 1 || o.cycles != 7) begin failures++; $display("FAIL rst_mid_next_write got=%0d/%0d want=1/7", o.ack_lat, o.cycles); end
        do_req(1'b0, 1'b0, 18'h00040, 16'hDEAD, 2'b11, o);
        checks++; if (a_rdata !== 16'h55AA) begin failures++; $display("FAIL rst_mid_readback got=%h want=55aa", a_rdata); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = 2'b00;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = 2'b00;

        test_reset();
        test_arbitration();
        test_write_a();
        test_read_b();
        test_partial_write();
        test_be_zero();
        test_reset_mid_access();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
